xgmii_rx_stats: RTL and testbench

XGMII_RX_STATS -- requirements
Module: xgmii_rx_stats

---
 rtl/xgmii_rx_stats.sv | 191 +++++++++++++++++++
 tb/tb_xgmii_rx_stats.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_rx_stats.sv
// xgmii_rx_stats: 64-bit XGMII receive frame classifier.
// Keeps totals, last frame length and per-window rate stats.
module xgmii_rx_stats #(
  parameter int unsigned TICK_CYCLES = 156250000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic        stats_clr,
  output logic [31:0] rx_frames,
  output logic [31:0] rx_bytes,
  output logic [31:0] rx_err_frames,
  output logic [15:0] rx_last_len,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput
);

  localparam int unsigned TW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  localparam logic [7:0] C_START = 8'hFB;
  localparam logic [7:0] C_TERM  = 8'hFD;
  localparam logic [7:0] C_ERR   = 8'hFE;

  typedef enum logic {
    S_IDLE,
    S_FRAME
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_acc;
  logic [15:0]   w_acc_nxt;
  logic          r_err;
  logic          w_err_nxt;

  logic          w_act;
  logic [15:0]   w_cnt;
  logic          w_err_run;
  logic [7:0]    w_ch;

  logic          w_done;
  logic          w_done_bad;
  logic [15:0]   w_done_cnt;

  logic [15:0]   w_len;
  logic          w_good;
  logic          w_bad;

  logic [TW-1:0] r_tick;
  logic          w_win_end;
  logic [31:0]   r_win_frames;
  logic [31:0]   r_win_bytes;
  logic [31:0]   w_win_frames_nxt;
  logic [31:0]   w_win_bytes_nxt;
  logic [32:0]   w_win_bytes_sum;

  // Frame FSM state and length accumulator
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Walk lanes in wire order; at most one completion per word,
  // a second in-word closure can only be a sub-preamble runt
  always_comb begin
    w_act      = (r_state == S_FRAME);
    w_cnt      = r_acc;
    w_err_run  = r_err;
    w_ch       = '0;
    w_done     = 1'b0;
    w_done_bad = 1'b0;
    w_done_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      w_ch = xgmii_rxd[8*i +: 8];
      if (xgmii_rxc[i] && w_ch == C_START &&
          (i == 0 || i == 4)) begin
        if (w_act && !w_done) begin
          w_done     = 1'b1;
          w_done_bad = 1'b1;
          w_done_cnt = w_cnt;
        end
        w_act     = 1'b1;
        w_cnt     = '0;
        w_err_run = 1'b0;
      end else if (w_act) begin
        if (!xgmii_rxc[i]) begin
          if (w_cnt != 16'hFFFF)
            w_cnt = w_cnt + 16'd1;
        end else if (w_ch == C_TERM) begin
          if (!w_done) begin
            w_done     = 1'b1;
            w_done_bad = w_err_run;
            w_done_cnt = w_cnt;
          end
          w_act = 1'b0;
        end else if (w_ch == C_ERR) begin
          w_err_run = 1'b1;
        end
      end
    end
    w_state_nxt = w_act ? S_FRAME : S_IDLE;
    w_acc_nxt   = w_act ? w_cnt : '0;
    w_err_nxt   = w_act & w_err_run;
  end

  // Classify the frame closed by this word (count excludes preamble+SFD)
  always_comb begin
    w_len  = (w_done_cnt > 16'd7) ? w_done_cnt - 16'd7 : 16'd0;
    w_good = w_done && !w_done_bad &&
             w_len >= 16'd64 && w_len <= 16'd1518;
    w_bad  = w_done && !w_good;
    w_win_frames_nxt = r_win_frames + {31'd0, w_good};
    w_win_bytes_sum  = {1'b0, r_win_bytes} +
                       {17'd0, w_good ? w_len : 16'd0};
    w_win_bytes_nxt  = w_win_bytes_sum[32] ? 32'hFFFF_FFFF
                                           : w_win_bytes_sum[31:0];
    w_win_end = (r_tick == TICK_LAST);
  end

  // Free-running window tick
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_tick <= '0;
    else if (w_win_end)
      r_tick <= '0;
    else
      r_tick <= r_tick + TW'(1);
  end

  // Running totals, cleared by stats_clr ahead of any completion
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_frames     <= '0;
      rx_bytes      <= '0;
      rx_err_frames <= '0;
    end else if (stats_clr) begin
      rx_frames     <= '0;
      rx_bytes      <= '0;
      rx_err_frames <= '0;
    end else if (w_good) begin
      rx_frames <= rx_frames + 32'd1;
      rx_bytes  <= rx_bytes + {16'd0, w_len};
    end else if (w_bad) begin
      rx_err_frames <= rx_err_frames + 32'd1;
    end
  end

  // Length of the latest completed frame, good or bad
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      rx_last_len <= '0;
    else if (w_done)
      rx_last_len <= w_len;
  end

  // Window accumulators; a completion on the end cycle joins the closing window
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_win_frames <= '0;
      r_win_bytes  <= '0;
    end else if (stats_clr || w_win_end) begin
      r_win_frames <= '0;
      r_win_bytes  <= '0;
    end else begin
      r_win_frames <= w_win_frames_nxt;
      r_win_bytes  <= w_win_bytes_nxt;
    end
  end

  // Published rate stats, refreshed only at window end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_pps        <= '0;
      rx_throughput <= '0;
    end else if (w_win_end) begin
      rx_pps        <= w_win_frames_nxt;
      rx_throughput <= w_win_bytes_nxt;
    end
  end

endmodule

// File: tb/tb_xgmii_rx_stats.sv
// tb_xgmii_rx_stats: frame-level stimulus for xgmii_rx_stats.
// Expected stats come from frame lengths and error flags.
module tb_xgmii_rx_stats;

  localparam int TICK = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] rxd = 64'h0707_0707_0707_0707;
  logic [7:0]  rxc = 8'hFF;
  logic [31:0] rx_frames, rx_bytes, rx_err, rx_pps, rx_thr;
  logic [15:0] rx_last;

  int checks = 0;
  int errors = 0;
  int nsteps = 0;

  logic [31:0] e_frames = 0;
  logic [31:0] e_bytes  = 0;
  logic [31:0] e_err    = 0;
  logic [15:0] e_last   = 0;

  logic [8:0] cq[$];

  xgmii_rx_stats #(.TICK_CYCLES(TICK)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .xgmii_rxd    (rxd),
    .xgmii_rxc    (rxc),
    .stats_clr    (clr),
    .rx_frames    (rx_frames),
    .rx_bytes     (rx_bytes),
    .rx_err_frames(rx_err),
    .rx_last_len  (rx_last),
    .rx_pps       (rx_pps),
    .rx_throughput(rx_thr)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [63:0] d, input logic [7:0] c);
    rxd = d;
    rxc = c;
    @(posedge clk);
    #1;
    nsteps++;
  endtask

  task automatic send_words(input int n);
    logic [63:0] d;
    logic [7:0]  c;
    logic [8:0]  ch;
    for (int w = 0; w < n; w++) begin
      for (int l = 0; l < 8; l++) begin
        ch = 9'h107;
        if (cq.size() > 0) ch = cq.pop_front();
        d[8*l +: 8] = ch[7:0];
        c[l] = ch[8];
      end
      step(d, c);
    end
  endtask

  task automatic send_all();
    while (cq.size() > 0) send_words(1);
  endtask

  // Frame as characters: optional 4 idles, S, 6x55, D5, payload, T, idle pad
  task automatic push_frame(input int len, input int align,
                            input bit err, input bit term);
    int ep;
    if (align == 4) repeat (4) cq.push_back(9'h107);
    cq.push_back(9'h1FB);
    repeat (6) cq.push_back(9'h055);
    cq.push_back(9'h0D5);
    ep = err ? int'($urandom_range(0, len - 1)) : -1;
    for (int i = 0; i < len; i++) begin
      if (i == ep) cq.push_back(9'h1FE);
      cq.push_back({1'b0, 8'($urandom)});
    end
    if (term) begin
      cq.push_back(9'h1FD);
      while (cq.size() % 8 != 0) cq.push_back(9'h107);
    end
  endtask

  function automatic void model_done(input int len, input bit err);
    if (err || len < 64 || len > 1518) e_err++;
    else begin
      e_frames++;
      e_bytes += 32'(len);
    end
    e_last = 16'(len);
  endfunction

  function automatic void model_clear();
    e_frames = 0;
    e_bytes  = 0;
    e_err    = 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    cq.delete();
    repeat (2) step(64'h0707_0707_0707_0707, 8'hFF);
    rst_n = 1'b1;
    nsteps = 0;
    model_clear();
    e_last = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (rx_frames !== 0) begin errors++; $display("FAIL rst_frames got=%0d exp=0", rx_frames); end
    checks++; if (rx_bytes !== 0) begin errors++; $display("FAIL rst_bytes got=%0d exp=0", rx_bytes); end
    checks++; if (rx_err !== 0) begin errors++; $display("FAIL rst_err got=%0d exp=0", rx_err); end
    checks++; if (rx_last !== 0) begin errors++; $display("FAIL rst_last got=%0d exp=0", rx_last); end
    checks++; if (rx_pps !== 0) begin errors++; $display("FAIL rst_pps got=%0d exp=0", rx_pps); end
    checks++; if (rx_thr !== 0) begin errors++; $display("FAIL rst_thr got=%0d exp=0", rx_thr); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nsteps = 0;
  endtask

  task automatic test_basic_64();
    push_frame(64, 0, 0, 1);
    send_words(9);
    checks++; if (rx_frames !== 0) begin errors++; $display("FAIL b64_early got=%0d exp=0", rx_frames); end
    send_words(1);
    model_done(64, 0);
    checks++; if (rx_frames !== e_frames) begin errors++; $display("FAIL b64_frames got=%0d exp=%0d", rx_frames, e_frames); end
    checks++; if (rx_bytes !== e_bytes) begin errors++; $display("FAIL b64_bytes got=%0d exp=%0d", rx_bytes, e_bytes); end
    checks++; if (rx_last !== e_last) begin errors++; $display("FAIL b64_last got=%0d exp=%0d", rx_last, e_last); end
    checks++; if (rx_err !== e_err) begin errors++; $display("FAIL b64_err got=%0d exp=%0d", rx_err, e_err); end
  endtask

  task automatic test_align4();
    push_frame(68, 4, 0, 1);
    send_all();
    model_done(68, 0);
    checks++; if (rx_last !== e_last) begin errors++; $display("FAIL a4_last got=%0d exp=%0d", rx_last, e_last); end
    checks++; if (rx_frames !== e_frames) begin errors++; $display("FAIL a4_frames got=%0d exp=%0d", rx_frames, e_frames); end
    checks++; if (rx_err !== e_err) begin errors++; $display("FAIL a4_err got=%0d exp=%0d", rx_err, e_err); end
    checks++; if (rx_bytes !== e_bytes) begin errors++; $display("FAIL a4_bytes got=%0d exp=%0d", rx_bytes, e_bytes); end
  endtask

  task automatic test_errors();
    int lens[6] = '{100, 60, 63, 64, 1518, 1519};
    bit errs[6] = '{1, 0, 0, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      push_frame(lens[k], k % 2 == 1 ? 4 : 0, errs[k], 1);
      send_all();
      model_done(lens[k], errs[k]);
      checks++; if (rx_frames !== e_frames) begin errors++; $display("FAIL err%0d_frames got=%0d exp=%0d", lens[k], rx_frames, e_frames); end
      checks++; if (rx_err !== e_err) begin errors++; $display("FAIL err%0d_err got=%0d exp=%0d", lens[k], rx_err, e_err); end
      checks++; if (rx_last !== e_last) begin errors++; $display("FAIL err%0d_last got=%0d exp=%0d", lens[k], rx_last, e_last); end
      send_words(1);
    end
  endtask

  task automatic test_back_to_back();
    push_frame(160, 0, 0, 0);
    send_all();
    checks++; if (rx_err !== e_err) begin errors++; $display("FAIL b2b_open got=%0d exp=%0d", rx_err, e_err); end
    push_frame(64, 0, 0, 1);
    send_words(1);
    model_done(160, 1);
    checks++; if (rx_err !== e_err) begin errors++; $display("FAIL b2b_err got=%0d exp=%0d", rx_err, e_err); end
    checks++; if (rx_last !== e_last) begin errors++; $display("FAIL b2b_last got=%0d exp=%0d", rx_last, e_last); end
    checks++; if (rx_frames !== e_frames) begin errors++; $display("FAIL b2b_frames0 got=%0d exp=%0d", rx_frames, e_frames); end
    send_all();
    model_done(64, 0);
    checks++; if (rx_frames !== e_frames) begin errors++; $display("FAIL b2b_frames got=%0d exp=%0d", rx_frames, e_frames); end
    checks++; if (rx_last !== e_last) begin errors++; $display("FAIL b2b_last2 got=%0d exp=%0d", rx_last, e_last); end
  endtask

  task automatic test_clr();
    clr = 1'b1;
    send_words(1);
    clr = 1'b0;
    model_clear();
    checks++; if (rx_frames !== 0 || rx_bytes !== 0 || rx_err !== 0) begin errors++; $display("FAIL clr_tot got=%0d/%0d/%0d exp=0/0/0", rx_frames, rx_bytes, rx_err); end
    checks++; if (rx_last !== e_last) begin errors++; $display("FAIL clr_last got=%0d exp=%0d", rx_last, e_last); end
    push_frame(64, 0, 0, 1);
    send_words(9);
    clr = 1'b1;
    send_words(1);
    clr = 1'b0;
    e_last = 64;
    checks++; if (rx_frames !== 0 || rx_bytes !== 0) begin errors++; $display("FAIL clr_prio got=%0d/%0d exp=0/0", rx_frames, rx_bytes); end
    push_frame(64, 4, 0, 1);
    send_all();
    model_done(64, 0);
    checks++; if (rx_frames !== e_frames) begin errors++; $display("FAIL clr_after got=%0d exp=%0d", rx_frames, e_frames); end
  endtask

  task automatic test_window();
    do_reset();
    repeat (3) begin
      push_frame(64, 0, 0, 1);
      send_all();
      model_done(64, 0);
    end
    send_words(99 - nsteps);
    checks++; if (rx_pps !== 0) begin errors++; $display("FAIL win1_early got=%0d exp=0", rx_pps); end
    send_words(1);
    checks++; if (rx_pps !== 3) begin errors++; $display("FAIL win1_pps got=%0d exp=3", rx_pps); end
    checks++; if (rx_thr !== 192) begin errors++; $display("FAIL win1_thr got=%0d exp=192", rx_thr); end
    clr = 1'b1;
    send_words(1);
    clr = 1'b0;
    model_clear();
    checks++; if (rx_pps !== 3) begin errors++; $display("FAIL win_clr_pps got=%0d exp=3", rx_pps); end
    checks++; if (rx_frames !== e_frames) begin errors++; $display("FAIL win_clr_frames got=%0d exp=%0d", rx_frames, e_frames); end
    send_words(200 - nsteps);
    checks++; if (rx_pps !== 0) begin errors++; $display("FAIL win2_pps got=%0d exp=0", rx_pps); end
    checks++; if (rx_thr !== 0) begin errors++; $display("FAIL win2_thr got=%0d exp=0", rx_thr); end
    push_frame(64, 0, 0, 1);
    send_all();
    clr = 1'b1;
    send_words(1);
    clr = 1'b0;
    model_clear();
    send_words(290 - nsteps);
    push_frame(64, 0, 0, 1);
    send_all();
    model_done(64, 0);
    checks++; if (nsteps !== 300) begin errors++; $display("FAIL win3_align got=%0d exp=300", nsteps); end
    checks++; if (rx_pps !== 1) begin errors++; $display("FAIL win3_pps got=%0d exp=1", rx_pps); end
    checks++; if (rx_thr !== 64) begin errors++; $display("FAIL win3_thr got=%0d exp=64", rx_thr); end
    checks++; if (rx_frames !== e_frames) begin errors++; $display("FAIL win3_frames got=%0d exp=%0d", rx_frames, e_frames); end
    send_words(400 - nsteps);
    checks++; if (rx_pps !== 0) begin errors++; $display("FAIL win4_pps got=%0d exp=0", rx_pps); end
  endtask

  task automatic test_reset_midframe();
    push_frame(200, 0, 0, 0);
    send_words(4);
    rst_n = 1'b0;
    #1;
    checks++; if (rx_frames !== 0 || rx_bytes !== 0 || rx_err !== 0) begin errors++; $display("FAIL rmid_tot got=%0d/%0d/%0d exp=0/0/0", rx_frames, rx_bytes, rx_err); end
    checks++; if (rx_last !== 0 || rx_pps !== 0 || rx_thr !== 0) begin errors++; $display("FAIL rmid_misc got=%0d/%0d/%0d exp=0/0/0", rx_last, rx_pps, rx_thr); end
    cq.delete();
    repeat (2) step(64'h0707_0707_0707_0707, 8'hFF);
    rst_n = 1'b1;
    model_clear();
    e_last = 0;
    repeat (20) cq.push_back(9'h0AA);
    cq.push_back(9'h1FD);
    while (cq.size() % 8 != 0) cq.push_back(9'h107);
    send_all();
    checks++; if (rx_frames !== 0 || rx_err !== 0) begin errors++; $display("FAIL rmid_tail got=%0d/%0d exp=0/0", rx_frames, rx_err); end
    push_frame(64, 0, 0, 1);
    send_all();
    model_done(64, 0);
    checks++; if (rx_frames !== e_frames) begin errors++; $display("FAIL rmid_frames got=%0d exp=%0d", rx_frames, e_frames); end
    checks++; if (rx_err !== e_err) begin errors++; $display("FAIL rmid_err got=%0d exp=%0d", rx_err, e_err); end
    checks++; if (rx_bytes !== e_bytes) begin errors++; $display("FAIL rmid_bytes got=%0d exp=%0d", rx_bytes, e_bytes); end
  endtask

  task automatic test_random();
    int len;
    int al;
    bit er;
    for (int k = 0; k < 25; k++) begin
      len = $urandom_range(40, 1600);
      al = ($urandom_range(0, 1) == 1) ? 4 : 0;
      er = ($urandom_range(0, 4) == 0);
      push_frame(len, al, er, 1);
      send_all();
      model_done(len, er);
      checks++; if (rx_frames !== e_frames) begin errors++; $display("FAIL rnd%0d_frames got=%0d exp=%0d", k, rx_frames, e_frames); end
      checks++; if (rx_bytes !== e_bytes) begin errors++; $display("FAIL rnd%0d_bytes got=%0d exp=%0d", k, rx_bytes, e_bytes); end
      checks++; if (rx_err !== e_err) begin errors++; $display("FAIL rnd%0d_err got=%0d exp=%0d", k, rx_err, e_err); end
      checks++; if (rx_last !== e_last) begin errors++; $display("FAIL rnd%0d_last got=%0d exp=%0d", k, rx_last, e_last); end
      send_words($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic_64();
    test_align4();
    test_errors();
    test_back_to_back();
    test_clr();
    test_window();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
